// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer: PC, imem handshake, IF/ID hand-off
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic        if_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic [15:0] pc_plus2,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_START,
    ST_FETCH,
    ST_HOLD,
    ST_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] instr_pc_q, instr_pc_d;
  logic        squash_q, squash_d;
  logic [15:0] seq_pc;

  assign seq_pc = instr_pc_q + 16'h0002;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_START;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= 16'h0000;
      instr_pc_q <= RESET_PC;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      squash_q   <= squash_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    squash_d   = squash_q;

    case (state_q)
      ST_START: begin
        state_d = ST_FETCH;
        if (redirect) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
        end else begin
          req_addr_d = pc_q;
        end
      end

      ST_FETCH: begin
        // req_addr stays frozen until the memory answers; a redirect while the
        // request is in flight only retargets pc and marks the reply as stale
        if (imem_ready) begin
          if (squash_q || redirect) begin
            squash_d = 1'b0;
            if (redirect) begin
              pc_d       = redirect_pc;
              req_addr_d = redirect_pc;
            end else begin
              req_addr_d = pc_q;
            end
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = ST_HOLD;
          end
        end else if (redirect) begin
          pc_d     = redirect_pc;
          squash_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
          state_d    = ST_FETCH;
        end else if (!stall) begin
          if (instr_q[15:12] == HALT_OPCODE) begin
            state_d = ST_HALT;
          end else begin
            pc_d       = seq_pc;
            req_addr_d = seq_pc;
            state_d    = ST_FETCH;
          end
        end
      end

      ST_HALT: begin
        // a redirect here means the HLT itself was on the wrong path
        if (redirect) begin
          pc_d       = redirect_pc;
          req_addr_d = redirect_pc;
          state_d    = ST_FETCH;
        end
      end

      default: state_d = ST_START;
    endcase
  end

  assign imem_req  = (state_q == ST_FETCH);
  assign if_valid  = (state_q == ST_HOLD);
  assign halted    = (state_q == ST_HALT);
  assign imem_addr = req_addr_q;
  assign instr     = instr_q;
  assign instr_pc  = instr_pc_q;
  assign pc_plus2  = seq_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed vector bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        if_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic [15:0] pc_plus2;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;

  fetch_sequencer #(
    .RESET_PC(16'h0000),
    .HALT_OPCODE(4'hF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .if_valid(if_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .pc_plus2(pc_plus2),
    .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic        rdy;
    logic [15:0] rdata;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_ipc;
    logic [15:0] e_p2;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rn, input logic st, input logic rd, input logic [15:0] rpc,
    input logic rdy, input logic [15:0] rdata,
    input logic e_req, input logic [15:0] e_addr, input logic e_valid,
    input logic [15:0] e_instr, input logic [15:0] e_ipc, input logic [15:0] e_p2,
    input logic e_halt);
    vec_t v;
    v.rst_n = rn; v.stall = st; v.redirect = rd; v.rpc = rpc;
    v.rdy = rdy; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_p2 = e_p2; v.e_halt = e_halt;
    return v;
  endfunction

  // drive at the falling edge, let one rising edge pass, check 1ns later
  task automatic apply(input vec_t v, input string tag);
    rst_n = v.rst_n; stall = v.stall; redirect = v.redirect;
    redirect_pc = v.rpc; imem_ready = v.rdy; imem_rdata = v.rdata;
    @(posedge clk);
    #1;
    n_vec++;
    if (imem_req !== v.e_req || imem_addr !== v.e_addr || if_valid !== v.e_valid ||
        instr !== v.e_instr || instr_pc !== v.e_ipc || pc_plus2 !== v.e_p2 ||
        halted !== v.e_halt) begin
      n_err++;
      $display("FAIL %s: got req=%b addr=%h valid=%b instr=%h ipc=%h p2=%h halt=%b, want req=%b addr=%h valid=%b instr=%h ipc=%h p2=%h halt=%b",
               tag, imem_req, imem_addr, if_valid, instr, instr_pc, pc_plus2, halted,
               v.e_req, v.e_addr, v.e_valid, v.e_instr, v.e_ipc, v.e_p2, v.e_halt);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    imem_ready = 1'b0; imem_rdata = 16'h0000;

    //              rn st rd rpc       rdy rdata      req addr      vld instr      ipc       p2        hlt
    // reset state
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h5555, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002, 0));
    // START ignores a response, then fetch 0000 with immediate ready
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hA000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hA000, 0, 16'h0000, 1, 16'hA000, 16'h0000, 16'h0002, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h0000, 1, 16'h0002, 0, 16'hA000, 16'h0000, 16'h0002, 0));
    // 0002 answered after three not-ready cycles; stall ignored in FETCH
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 16'hBEEF, 1, 16'h0002, 0, 16'hA000, 16'h0000, 16'h0002, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'hBEEF, 1, 16'h0002, 0, 16'hA000, 16'h0000, 16'h0002, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'hBEEF, 1, 16'h0002, 0, 16'hA000, 16'h0000, 16'h0002, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hA002, 0, 16'h0002, 1, 16'hA002, 16'h0002, 16'h0004, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 16'hA002, 16'h0002, 16'h0004, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hA004, 0, 16'h0004, 1, 16'hA004, 16'h0004, 16'h0006, 0));
    // HOLD on 0004 with stall for five cycles
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h1111, 0, 16'h0004, 1, 16'hA004, 16'h0004, 16'h0006, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 0, 16'hA004, 16'h0004, 16'h0006, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hA006, 0, 16'h0006, 1, 16'hA006, 16'h0006, 16'h0008, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 0, 16'hA006, 16'h0006, 16'h0008, 0));
    // redirect to 0040 during the first cycle of a 3-cycle request to 0008
    vecs.push_back(mk(1, 0, 1, 16'h0040, 0, 16'h0000, 1, 16'h0008, 0, 16'hA006, 16'h0006, 16'h0008, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 0, 16'hA006, 16'h0006, 16'h0008, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hA008, 1, 16'h0040, 0, 16'hA006, 16'h0006, 16'h0008, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hA040, 0, 16'h0040, 1, 16'hA040, 16'h0040, 16'h0042, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0042, 0, 16'hA040, 16'h0040, 16'h0042, 0));
    // redirect to 0080 in the same cycle the memory answers
    vecs.push_back(mk(1, 0, 1, 16'h0080, 1, 16'hA042, 1, 16'h0080, 0, 16'hA040, 16'h0040, 16'h0042, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hA080, 0, 16'h0080, 1, 16'hA080, 16'h0080, 16'h0082, 0));
    // redirect to 00C0 beats stall in HOLD
    vecs.push_back(mk(1, 1, 1, 16'h00C0, 0, 16'h0000, 1, 16'h00C0, 0, 16'hA080, 16'h0080, 16'h0082, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hA0C0, 0, 16'h00C0, 1, 16'hA0C0, 16'h00C0, 16'h00C2, 0));
    // redirect to 0010 where an HLT lives
    vecs.push_back(mk(1, 0, 1, 16'h0010, 0, 16'h0000, 1, 16'h0010, 0, 16'hA0C0, 16'h00C0, 16'h00C2, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hF000, 0, 16'h0010, 1, 16'hF000, 16'h0010, 16'h0012, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 0, 16'hF000, 16'h0010, 16'h0012, 1));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h1234, 0, 16'h0010, 0, 16'hF000, 16'h0010, 16'h0012, 1));
    vecs.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h1234, 0, 16'h0010, 0, 16'hF000, 16'h0010, 16'h0012, 1));
    // redirect out of HALT
    vecs.push_back(mk(1, 0, 1, 16'h0020, 0, 16'h0000, 1, 16'h0020, 0, 16'hF000, 16'h0010, 16'h0012, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hA020, 0, 16'h0020, 1, 16'hA020, 16'h0020, 16'h0022, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0022, 0, 16'hA020, 16'h0020, 16'h0022, 0));
    // reset while the request to 0022 is outstanding
    vecs.push_back(mk(0, 0, 0, 16'h0000, 1, 16'hA022, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002, 0));

    @(negedge clk);
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // redirect straight out of START, then PC wrap at FFFE
    apply(mk(1, 0, 1, 16'hFFFE, 0, 16'h0000, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, 16'h0002, 0), "start_redirect");
    apply(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, 16'h0002, 0), "wrap_wait");
    apply(mk(1, 0, 0, 16'h0000, 1, 16'h7123, 0, 16'hFFFE, 1, 16'h7123, 16'hFFFE, 16'h0000, 0), "wrap_hold");
    apply(mk(1, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h7123, 16'hFFFE, 16'h0000, 0), "wrap_next");

    // odd redirect target passes through unmodified; squash then clean fetch
    apply(mk(1, 0, 1, 16'h1235, 0, 16'h0000, 1, 16'h0000, 0, 16'h7123, 16'hFFFE, 16'h0000, 0), "odd_redirect");
    apply(mk(1, 0, 0, 16'h0000, 1, 16'hA000, 1, 16'h1235, 0, 16'h7123, 16'hFFFE, 16'h0000, 0), "odd_squash");
    apply(mk(1, 0, 0, 16'h0000, 1, 16'h4444, 0, 16'h1235, 1, 16'h4444, 16'h1235, 16'h1237, 0), "odd_hold");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
